// File: rtl/l1_icache.sv
// 2-way set-associative read-only L1 instruction cache with 1-bit LRU per set.
// Hits return in the same cycle; a miss takes 2 cycles plus memory latency.
// A miss stalls the fetch (icache_resp=0) and holds pmem_read until pmem_resp.
module l1_icache #(
  parameter int s_index = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  icache_addr,
  input  logic         icache_read,
  output logic         icache_resp,
  output logic [127:0] icache_rdata,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
);

  localparam int SETS  = 1 << s_index;
  localparam int TAG_W = 12 - s_index;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Per-way storage: valid bits are reset, tags and data need not be.
  logic [SETS-1:0]  r_valid0;
  logic [SETS-1:0]  r_valid1;
  logic [TAG_W-1:0] r_tag0  [SETS];
  logic [TAG_W-1:0] r_tag1  [SETS];
  logic [127:0]     r_data0 [SETS];
  logic [127:0]     r_data1 [SETS];
  // LRU bit names the way to replace next.
  logic [SETS-1:0]  r_lru;

  logic [15:0]      r_miss_addr;
  logic             r_victim;
  logic [15:0]      r_hit_count;
  logic [15:0]      r_miss_count;

  logic [s_index-1:0] w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [s_index-1:0] w_fill_idx;
  logic [TAG_W-1:0]   w_fill_tag;
  logic               w_way0_hit;
  logic               w_way1_hit;
  logic               w_lookup;
  logic               w_hit;
  logic               w_miss;
  logic               w_fill;
  logic               w_unused_offset;

  assign w_idx      = icache_addr[3+s_index:4];
  assign w_tag      = icache_addr[15:4+s_index];
  assign w_fill_idx = r_miss_addr[3+s_index:4];
  assign w_fill_tag = r_miss_addr[15:4+s_index];

  // Byte offset selects within the line in the fetch stage, not here.
  assign w_unused_offset = ^icache_addr[3:0];

  assign w_way0_hit = r_valid0[w_idx] && (r_tag0[w_idx] == w_tag);
  assign w_way1_hit = r_valid1[w_idx] && (r_tag1[w_idx] == w_tag);

  // Lookups only happen in IDLE and never during the reset cycle.
  assign w_lookup = (r_state == ST_IDLE) && icache_read && !reset;
  assign w_hit    = w_lookup && (w_way0_hit || w_way1_hit);
  assign w_miss   = w_lookup && !(w_way0_hit || w_way1_hit);
  assign w_fill   = (r_state == ST_FETCH) && pmem_resp && !reset;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: leave IDLE on a miss, return once the fill lands.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_miss) w_next_state = ST_FETCH;
      ST_FETCH: if (pmem_resp) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Outputs: combinational hit path and registered miss address.
  always_comb begin
    icache_resp  = w_hit;
    icache_rdata = w_way1_hit ? r_data1[w_idx] : r_data0[w_idx];
    pmem_read    = (r_state == ST_FETCH) && !reset;
    pmem_address = pmem_read ? r_miss_addr : 16'h0000;
  end

  // Control state: valid bits, LRU, miss latch and saturating counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid0     <= '0;
      r_valid1     <= '0;
      r_lru        <= '0;
      r_miss_addr  <= 16'h0000;
      r_victim     <= 1'b0;
      r_hit_count  <= 16'h0000;
      r_miss_count <= 16'h0000;
    end else begin
      if (w_hit) begin
        // The way that did not hit becomes the replacement candidate.
        r_lru[w_idx] <= w_way0_hit;
        if (r_hit_count != 16'hFFFF) r_hit_count <= r_hit_count + 16'd1;
      end
      if (w_miss) begin
        r_miss_addr <= {icache_addr[15:4], 4'h0};
        r_victim    <= r_lru[w_idx];
        if (r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
      end
      if (w_fill) begin
        if (r_victim) r_valid1[w_fill_idx] <= 1'b1;
        else          r_valid0[w_fill_idx] <= 1'b1;
        r_lru[w_fill_idx] <= ~r_victim;
      end
    end
  end

  // Line storage write on fill completion; abandoned fills write nothing.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      if (r_victim) begin
        r_tag1[w_fill_idx]  <= w_fill_tag;
        r_data1[w_fill_idx] <= pmem_rdata;
      end else begin
        r_tag0[w_fill_idx]  <= w_fill_tag;
        r_data0[w_fill_idx] <= pmem_rdata;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

endmodule

// File: tb/tb_l1_icache.sv
// Directed bench for l1_icache: misses, fills, LRU eviction, reset and counters.
// Inputs change just after the falling edge; outputs are sampled 1 ns later.
// Memory responses are driven by hand with a fixed latency per scenario.
module tb_l1_icache;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [15:0]  icache_addr = 16'h0000;
  logic         icache_read = 1'b0;
  logic         icache_resp;
  logic [127:0] icache_rdata;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic [127:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  l1_icache #(.s_index(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .icache_addr  (icache_addr),
    .icache_read  (icache_read),
    .icache_resp  (icache_resp),
    .icache_rdata (icache_rdata),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  function automatic logic [127:0] mk_line(input logic [15:0] a);
    return {4{a, ~a}};
  endfunction

  task automatic apply_reset;
    @(negedge clk);
    reset = 1'b1; icache_read = 1'b0; icache_addr = 16'h0000;
    pmem_resp = 1'b0; pmem_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  // Waits (bounded) for pmem_read, holds it for lat cycles, then pulses pmem_resp.
  // ok=0 if the request never appears or the address/strobe wavers.
  task automatic serve(input int lat, input logic [127:0] data,
                       output logic [15:0] a, output bit ok);
    ok = 1'b0;
    a  = 16'h0000;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk); #1;
      if (pmem_read === 1'b1) break;
    end
    if (pmem_read !== 1'b1) return;
    a  = pmem_address;
    ok = 1'b1;
    for (int k = 1; k < lat; k++) begin
      @(negedge clk); #1;
      if (pmem_read !== 1'b1 || pmem_address !== a) ok = 1'b0;
    end
    pmem_resp = 1'b1; pmem_rdata = data;
    @(negedge clk);
    pmem_resp = 1'b0; pmem_rdata = '0;
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1; icache_read = 1'b1; icache_addr = 16'h0100; pmem_resp = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    checks++; if (icache_resp !== 1'b0) begin errors++; $display("FAIL rst_resp got=%b exp=0", icache_resp); end
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL rst_pmem_read got=%b exp=0", pmem_read); end
    checks++; if (pmem_address !== 16'h0000) begin errors++; $display("FAIL rst_pmem_addr got=%h exp=0000", pmem_address); end
    checks++; if (hit_count !== 16'h0000) begin errors++; $display("FAIL rst_hit_count got=%h exp=0000", hit_count); end
    checks++; if (miss_count !== 16'h0000) begin errors++; $display("FAIL rst_miss_count got=%h exp=0000", miss_count); end
    reset = 1'b0; icache_read = 1'b0;
    @(negedge clk); #1;
    checks++; if (icache_resp !== 1'b0 || pmem_read !== 1'b0) begin errors++; $display("FAIL idle_quiet got resp=%b pread=%b exp 0/0", icache_resp, pmem_read); end
  endtask

  task automatic test_cold_miss;
    logic [15:0] a; bit ok;
    apply_reset;
    icache_addr = 16'h0106; icache_read = 1'b1; #1;
    checks++; if (icache_resp !== 1'b0) begin errors++; $display("FAIL cold_resp got=%b exp=0", icache_resp); end
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL cold_pread_early got=%b exp=0", pmem_read); end
    serve(3, mk_line(16'h0100), a, ok);
    checks++; if (ok !== 1'b1 || a !== 16'h0100) begin errors++; $display("FAIL cold_req got ok=%b addr=%h exp ok=1 addr=0100", ok, a); end
    checks++; if (icache_resp !== 1'b1) begin errors++; $display("FAIL cold_hit_resp got=%b exp=1", icache_resp); end
    checks++; if (icache_rdata !== mk_line(16'h0100)) begin errors++; $display("FAIL cold_rdata got=%h exp=%h", icache_rdata, mk_line(16'h0100)); end
    checks++; if (miss_count !== 16'd1) begin errors++; $display("FAIL cold_miss_count got=%0d exp=1", miss_count); end
    checks++; if (hit_count !== 16'd0) begin errors++; $display("FAIL cold_hit_count0 got=%0d exp=0", hit_count); end
    @(negedge clk); #1;
    checks++; if (hit_count !== 16'd1) begin errors++; $display("FAIL cold_hit_count1 got=%0d exp=1", hit_count); end
  endtask

  task automatic test_lru;
    logic [15:0] a; bit ok;
    apply_reset;
    icache_read = 1'b1; icache_addr = 16'h0100;
    serve(2, mk_line(16'h0100), a, ok);
    checks++; if (ok !== 1'b1 || a !== 16'h0100) begin errors++; $display("FAIL lru_fill0 got ok=%b addr=%h exp 1/0100", ok, a); end
    icache_addr = 16'h0900; #1;
    checks++; if (icache_resp !== 1'b0) begin errors++; $display("FAIL lru_0900_miss got=%b exp=0", icache_resp); end
    serve(2, mk_line(16'h0900), a, ok);
    checks++; if (ok !== 1'b1 || a !== 16'h0900) begin errors++; $display("FAIL lru_fill1 got ok=%b addr=%h exp 1/0900", ok, a); end
    checks++; if (icache_resp !== 1'b1 || icache_rdata !== mk_line(16'h0900)) begin errors++; $display("FAIL lru_0900_hit got resp=%b data=%h", icache_resp, icache_rdata); end
    icache_addr = 16'h0100; #1;
    checks++; if (icache_resp !== 1'b1 || icache_rdata !== mk_line(16'h0100)) begin errors++; $display("FAIL lru_0100_hit got resp=%b data=%h", icache_resp, icache_rdata); end
    @(negedge clk);
    icache_addr = 16'h1100; #1;
    checks++; if (icache_resp !== 1'b0) begin errors++; $display("FAIL lru_1100_miss got=%b exp=0", icache_resp); end
    serve(2, mk_line(16'h1100), a, ok);
    checks++; if (ok !== 1'b1 || a !== 16'h1100) begin errors++; $display("FAIL lru_fill_1100 got ok=%b addr=%h exp 1/1100", ok, a); end
    checks++; if (icache_resp !== 1'b1 || icache_rdata !== mk_line(16'h1100)) begin errors++; $display("FAIL lru_1100_hit got resp=%b data=%h", icache_resp, icache_rdata); end
    icache_addr = 16'h0100; #1;
    checks++; if (icache_resp !== 1'b1 || icache_rdata !== mk_line(16'h0100)) begin errors++; $display("FAIL lru_0100_kept got resp=%b data=%h", icache_resp, icache_rdata); end
    @(negedge clk);
    icache_addr = 16'h0900; #1;
    checks++; if (icache_resp !== 1'b0) begin errors++; $display("FAIL lru_0900_evicted got=%b exp=0", icache_resp); end
    serve(2, mk_line(16'h0900), a, ok);
    checks++; if (ok !== 1'b1 || a !== 16'h0900) begin errors++; $display("FAIL lru_refill_0900 got ok=%b addr=%h exp 1/0900", ok, a); end
    checks++; if (miss_count !== 16'd4) begin errors++; $display("FAIL lru_miss_count got=%0d exp=4", miss_count); end
    checks++; if (hit_count !== 16'd2) begin errors++; $display("FAIL lru_hit_count got=%0d exp=2", hit_count); end
  endtask

  task automatic test_addr_change;
    logic [15:0] a; bit ok;
    apply_reset;
    icache_read = 1'b1; icache_addr = 16'h0200;
    @(negedge clk); #1;
    checks++; if (pmem_read !== 1'b1 || pmem_address !== 16'h0200) begin errors++; $display("FAIL chg_req got pread=%b addr=%h exp 1/0200", pmem_read, pmem_address); end
    icache_addr = 16'h0300; #1;
    checks++; if (icache_resp !== 1'b0) begin errors++; $display("FAIL chg_no_resp got=%b exp=0", icache_resp); end
    @(negedge clk); #1;
    checks++; if (pmem_read !== 1'b1 || pmem_address !== 16'h0200) begin errors++; $display("FAIL chg_addr_stable got pread=%b addr=%h exp 1/0200", pmem_read, pmem_address); end
    pmem_resp = 1'b1; pmem_rdata = mk_line(16'h0200);
    @(negedge clk);
    pmem_resp = 1'b0; pmem_rdata = '0; #1;
    checks++; if (icache_resp !== 1'b0 || pmem_read !== 1'b0) begin errors++; $display("FAIL chg_0300_miss got resp=%b pread=%b exp 0/0", icache_resp, pmem_read); end
    serve(1, mk_line(16'h0300), a, ok);
    checks++; if (ok !== 1'b1 || a !== 16'h0300) begin errors++; $display("FAIL chg_fill_0300 got ok=%b addr=%h exp 1/0300", ok, a); end
    checks++; if (icache_resp !== 1'b1 || icache_rdata !== mk_line(16'h0300)) begin errors++; $display("FAIL chg_0300_hit got resp=%b data=%h", icache_resp, icache_rdata); end
    icache_addr = 16'h0200; #1;
    checks++; if (icache_resp !== 1'b1 || icache_rdata !== mk_line(16'h0200)) begin errors++; $display("FAIL chg_0200_installed got resp=%b data=%h", icache_resp, icache_rdata); end
  endtask

  task automatic test_reset_mid_fill;
    apply_reset;
    // A stray pmem_resp while idle must not install anything.
    icache_read = 1'b0; pmem_resp = 1'b1; pmem_rdata = mk_line(16'h0400);
    @(negedge clk);
    pmem_resp = 1'b0; pmem_rdata = '0;
    icache_read = 1'b1; icache_addr = 16'h0400; #1;
    checks++; if (icache_resp !== 1'b0) begin errors++; $display("FAIL idle_resp_ignored got=%b exp=0", icache_resp); end
    @(negedge clk); #1;
    checks++; if (pmem_read !== 1'b1 || miss_count !== 16'd1) begin errors++; $display("FAIL rmf_fetch got pread=%b misses=%0d exp 1/1", pmem_read, miss_count); end
    pmem_resp = 1'b1; pmem_rdata = mk_line(16'h0400); reset = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0; pmem_rdata = '0; reset = 1'b0; #1;
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL rmf_pread_drop got=%b exp=0", pmem_read); end
    checks++; if (icache_resp !== 1'b0) begin errors++; $display("FAIL rmf_not_installed got=%b exp=0", icache_resp); end
    checks++; if (miss_count !== 16'd0 || hit_count !== 16'd0) begin errors++; $display("FAIL rmf_counters got hits=%0d misses=%0d exp 0/0", hit_count, miss_count); end
    @(negedge clk); #1;
    checks++; if (pmem_read !== 1'b1 || pmem_address !== 16'h0400 || miss_count !== 16'd1) begin errors++; $display("FAIL rmf_remiss got pread=%b addr=%h misses=%0d exp 1/0400/1", pmem_read, pmem_address, miss_count); end
    pmem_resp = 1'b1; pmem_rdata = mk_line(16'h0400);
    @(negedge clk);
    pmem_resp = 1'b0; pmem_rdata = '0; #1;
    checks++; if (icache_resp !== 1'b1 || icache_rdata !== mk_line(16'h0400)) begin errors++; $display("FAIL rmf_refill_hit got resp=%b data=%h", icache_resp, icache_rdata); end
  endtask

  task automatic test_sustained;
    logic [15:0] a; bit ok;
    apply_reset;
    icache_read = 1'b1; icache_addr = 16'h0500;
    serve(2, mk_line(16'h0500), a, ok);
    checks++; if (ok !== 1'b1 || a !== 16'h0500) begin errors++; $display("FAIL sus_fill got ok=%b addr=%h exp 1/0500", ok, a); end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (icache_resp !== 1'b1 || pmem_read !== 1'b0 || icache_rdata !== mk_line(16'h0500)) begin
        errors++; $display("FAIL sus_cycle%0d got resp=%b pread=%b exp 1/0", i, icache_resp, pmem_read);
      end
      @(negedge clk); #1;
    end
    checks++; if (hit_count !== 16'd10) begin errors++; $display("FAIL sus_hit_count got=%0d exp=10", hit_count); end
    icache_read = 1'b0;
    @(negedge clk); #1;
    checks++; if (hit_count !== 16'd10 || icache_resp !== 1'b0) begin errors++; $display("FAIL sus_idle got hits=%0d resp=%b exp 10/0", hit_count, icache_resp); end
  endtask

  task automatic test_saturation;
    logic [15:0] a; bit ok;
    apply_reset;
    icache_read = 1'b1; icache_addr = 16'h0600;
    serve(2, mk_line(16'h0600), a, ok);
    checks++; if (ok !== 1'b1 || a !== 16'h0600) begin errors++; $display("FAIL sat_fill got ok=%b addr=%h exp 1/0600", ok, a); end
    repeat (65534) @(negedge clk);
    #1;
    checks++; if (hit_count !== 16'hFFFE) begin errors++; $display("FAIL sat_near got=%h exp=fffe", hit_count); end
    repeat (6) @(negedge clk);
    #1;
    checks++; if (hit_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%h exp=ffff", hit_count); end
    checks++; if (miss_count !== 16'd1) begin errors++; $display("FAIL sat_miss_count got=%0d exp=1", miss_count); end
  endtask

  initial begin
    test_reset;
    test_cold_miss;
    test_lru;
    test_addr_change;
    test_reset_mid_fill;
    test_sustained;
    test_saturation;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
